wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
// Two-master Wishbone classic arbiter: the initiator-side counterpart of the address decoder.
// It merges two bus masters (e.g. CPU instruction and data ports) onto one shared bus whose
// address the decoder fans out to the slaves. Round-robin grant is held for a whole cycle (CYC).
// A bus watchdog answers unacknowledged strobes with ERR.
// PARAMETERS
// ADR_W    32  address width
// DAT_W    32  data width; SEL width = DAT_W/8
// TIMEOUT  255 cycles of unanswered strobe before watchdog ERR; 0 disables the watchdog
// PORTS
// clk_i                  in   1        single clock, all logic on rising edge
// rst_i                  in   1        synchronous, active-high reset
// m0_cyc_i / m1_cyc_i    in   1        master bus-cycle request
// m0_stb_i / m1_stb_i    in   1        master strobe
// m0_we_i  / m1_we_i     in   1        master write enable
// m0_adr_i / m1_adr_i    in   ADR_W    master address
// m0_dat_i / m1_dat_i    in   DAT_W    master write data
// m0_sel_i / m1_sel_i    in   DAT_W/8  master byte selects
// m0_ack_o / m1_ack_o    out  1        ack, to owner only
// m0_err_o / m1_err_o    out  1        err (slave or watchdog), to owner only
// m0_dat_o / m1_dat_o    out  DAT_W    read data, both = s_dat_i
// s_cyc_o, s_stb_o, s_we_o  out 1      shared-bus controls from owner
// s_adr_o  out ADR_W; s_dat_o out DAT_W; s_sel_o out DAT_W/8   owner's payload
// s_ack_i, s_err_i       in   1        shared-bus response
// s_dat_i                in   DAT_W    shared-bus read data
// gnt_o                  out  2        one-hot current owner; 00 when idle
// timeout_o              out  1        one-cycle pulse when the watchdog fires
// BEHAVIOUR
// - State: IDLE, OWN0, OWN1 (registered); last_owner register; watchdog counter wdt,
//   width $clog2(TIMEOUT+1).
// - Reset: state=IDLE, last_owner=1 (m0 wins the first tie), wdt=0. gnt_o=00, timeout_o=0,
//   all ack/err=0, s_cyc_o=s_stb_o=s_we_o=0. rst_i mid-cycle aborts the transfer at once.
// - IDLE: only one cyc high -> grant that master at next edge. Both high -> grant the master
//   that is not last_owner. Neither high -> stay. Arbitration latency is 1 cycle.
// - OWNn: s_* = mn_* combinationally (s_cyc_o=mn_cyc_i). Owner keeps the bus while
//   mn_cyc_i=1 (block/RMW cycles are not preempted). mn_cyc_i=0 at edge -> IDLE,
//   last_owner<=n. Minimum one IDLE cycle between owners.
// - IDLE drives s_cyc_o=s_stb_o=s_we_o=0. s_adr_o/s_dat_o/s_sel_o are don't-care (drive m0's).
// - Responses: mn_ack_o=s_ack_i & gnt[n]; mn_err_o=(s_err_i | wdt_fire) & gnt[n]. A
//   non-owner never sees ack/err. s_ack_i and s_err_i together pass both through unchanged.
// - Watchdog (TIMEOUT>0):
//   - wdt increments each cycle s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i.
//   - wdt clears on ack/err, when stb is low, or when the owner drops cyc.
//   - wdt_fire = (wdt==TIMEOUT) & s_stb_o & ~s_ack_i & ~s_err_i. It asserts owner err and
//     timeout_o for exactly 1 cycle, and wdt clears the same edge.
//   - Owner then completes per Wishbone. No wdt wrap: it saturates via fire/clear.
// - TIMEOUT=0: wdt held at 0, wdt_fire=0, timeout_o=0.
// - Owner drops cyc with stb pending (abort): -> IDLE, wdt cleared, no response generated.
// TESTING
// 1 reset: assert rst_i 2 cycles with both cyc=1 -> gnt_o=00, all ack/err/s_cyc_o=0;
//   after release, m0 is granted 1 cycle later (gnt_o=01).
// 2 round-robin: both cyc held and each drops after one acked transfer -> grants alternate
//   01,00,10,00,01 with one IDLE cycle between.
// 3 hold: m0 does 4-beat block (cyc held, stb toggled) while m1 requests -> m1 waits;
//   gnt_o=10 one cycle after m0 cyc drop.
// 4 routing: m1 owner reads adr 0x1000_0004, slave returns ack, dat 0xDEAD_BEEF ->
//   m1_ack_o=1, m1_dat_o=0xDEAD_BEEF, m0_ack_o=0.
// 5 watchdog: TIMEOUT=4, m0 stb with no slave ack -> m0_err_o and timeout_o high 1 cycle
//   at 5th stb cycle; TIMEOUT=0 -> never.
// 6 abort/reset mid-op: owner drops cyc mid-wait -> IDLE, wdt=0; rst_i during OWN1 ->
//   IDLE next edge, s_cyc_o=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter with round-robin grant per CYC.
// A watchdog answers strobes left unacknowledged for TIMEOUT cycles with ERR.
module wb_arbiter #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    output logic [DAT_W-1:0]   m0_dat_o,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic [DAT_W-1:0]   m1_dat_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    input  logic [DAT_W-1:0]   s_dat_i,
    output logic [1:0]         gnt_o,
    output logic               timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic [1:0] w_gnt;
    logic       w_fire;
    logic       w_wait;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // The owner keeps the bus until it drops CYC; ties go to the other master.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        unique case (r_state)
            S_IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    w_state_nxt = r_last ? S_OWN0 : S_OWN1;
                else if (m0_cyc_i)
                    w_state_nxt = S_OWN0;
                else if (m1_cyc_i)
                    w_state_nxt = S_OWN1;
            end
            S_OWN0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = 1'b0;
                end
            end
            S_OWN1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        unique case (r_state)
            S_OWN0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
            end
            S_OWN1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
            end
            default: ;
        endcase
    end

    assign w_gnt = {r_state == S_OWN1, r_state == S_OWN0};
    assign w_wait = s_stb_o & ~s_ack_i & ~s_err_i;

    generate
        if (TIMEOUT > 0) begin : g_wdt
            localparam int WDT_W = $clog2(TIMEOUT + 1);
            logic [WDT_W-1:0] r_wdt;

            assign w_fire = (r_wdt == WDT_W'(TIMEOUT)) & w_wait;

            // Clearing on fire keeps the counter from ever wrapping.
            always_ff @(posedge clk_i) begin
                if (rst_i)
                    r_wdt <= '0;
                else if (s_cyc_o && w_wait && !w_fire)
                    r_wdt <= r_wdt + WDT_W'(1);
                else
                    r_wdt <= '0;
            end
        end else begin : g_no_wdt
            assign w_fire = 1'b0;
        end
    endgenerate

    assign m0_ack_o  = s_ack_i & w_gnt[0];
    assign m1_ack_o  = s_ack_i & w_gnt[1];
    assign m0_err_o  = (s_err_i | w_fire) & w_gnt[0];
    assign m1_err_o  = (s_err_i | w_fire) & w_gnt[1];
    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign gnt_o     = w_gnt;
    assign timeout_o = w_fire;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grant order, hold, routing,
// watchdog (TIMEOUT=4 and TIMEOUT=0), abort and reset mid-cycle.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat;
    logic [3:0]  m0_sel;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat;
    logic [3:0]  m1_sel;
    logic        s_ack, s_err;
    logic [31:0] s_dat_in;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic [1:0]  gnt;
    logic        tmo;

    logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
    logic [31:0] z_m0_rd, z_m1_rd;
    logic        z_s_cyc, z_s_stb, z_s_we;
    logic [31:0] z_s_adr, z_s_dat;
    logic [3:0]  z_s_sel;
    logic [1:0]  z_gnt;
    logic        z_tmo;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.ADR_W(32), .DAT_W(32), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rd),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rd),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat_in),
        .gnt_o(gnt), .timeout_o(tmo)
    );

    wb_arbiter #(.ADR_W(32), .DAT_W(32), .TIMEOUT(0)) dut_nowdt (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
        .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err), .m0_dat_o(z_m0_rd),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
        .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err), .m1_dat_o(z_m1_rd),
        .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we),
        .s_adr_o(z_s_adr), .s_dat_o(z_s_dat), .s_sel_o(z_s_sel),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat_in),
        .gnt_o(z_gnt), .timeout_o(z_tmo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        s_ack = 1'b1; s_err = 1'b1;
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL rst_gnt got %b exp 00", gnt);
        end
        vectors++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_resp got %b exp 0000",
                     {m0_ack, m0_err, m1_ack, m1_err});
        end
        vectors++;
        if ({s_cyc, s_stb, s_we, tmo} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_bus got %b exp 0000", {s_cyc, s_stb, s_we, tmo});
        end
        s_ack = 1'b0; s_err = 1'b0;
        rst = 1'b0;
        step();
        vectors++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL rst_first_gnt got %b exp 01", gnt);
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        vectors++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL rr_gnt0 got %b exp 01", gnt);
        end
        s_ack = 1'b1;
        #1;
        vectors++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            errors++; $display("FAIL rr_ack0 got %b exp 10", {m0_ack, m1_ack});
        end
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        step();
        vectors++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL rr_idle0 got %b exp 00", gnt);
        end
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        vectors++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL rr_gnt1 got %b exp 10", gnt);
        end
        s_ack = 1'b1;
        #1;
        vectors++;
        if ({m0_ack, m1_ack} !== 2'b01) begin
            errors++; $display("FAIL rr_ack1 got %b exp 01", {m0_ack, m1_ack});
        end
        step();
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        step();
        vectors++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL rr_idle1 got %b exp 00", gnt);
        end
        step();
        vectors++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL rr_gnt2 got %b exp 01", gnt);
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        step();
    endtask

    task automatic test_hold();
        m0_cyc = 1'b1; m0_stb = 1'b0;
        step();
        m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m0_stb = 1'b1; s_ack = 1'b1;
            #1;
            vectors++;
            if ({gnt, m0_ack, m1_ack} !== 4'b0110) begin
                errors++;
                $display("FAIL hold_beat%0d got %b exp 0110", b,
                         {gnt, m0_ack, m1_ack});
            end
            step();
            m0_stb = 1'b0; s_ack = 1'b0;
            step();
        end
        m0_cyc = 1'b0;
        step();
        vectors++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL hold_idle got %b exp 00", gnt);
        end
        step();
        vectors++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL hold_gnt1 got %b exp 10", gnt);
        end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        step();
    endtask

    task automatic test_routing();
        m0_adr = 32'hAAAA_0000; m0_dat = 32'h0BAD_0BAD; m0_sel = 4'h3;
        #1;
        vectors++;
        if ({s_cyc, s_adr, s_sel} !== {1'b0, 32'hAAAA_0000, 4'h3}) begin
            errors++;
            $display("FAIL idle_bus got cyc=%b adr=%h sel=%h exp 0 aaaa0000 3",
                     s_cyc, s_adr, s_sel);
        end
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0;
        m1_adr = 32'h1000_0004; m1_sel = 4'hF;
        step();
        vectors++;
        if ({gnt, s_cyc, s_stb, s_we, s_adr, s_sel} !==
            {2'b10, 3'b110, 32'h1000_0004, 4'hF}) begin
            errors++;
            $display("FAIL route_req got gnt=%b cyc/stb/we=%b adr=%h sel=%h",
                     gnt, {s_cyc, s_stb, s_we}, s_adr, s_sel);
        end
        s_ack = 1'b1; s_dat_in = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if ({m1_ack, m0_ack, m1_rd, m0_rd} !==
            {2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL route_rd got ack1=%b ack0=%b d1=%h d0=%h exp 1 0 deadbeef",
                     m1_ack, m0_ack, m1_rd, m0_rd);
        end
        s_err = 1'b1;
        #1;
        vectors++;
        if ({m1_ack, m1_err, m0_ack, m0_err} !== 4'b1100) begin
            errors++;
            $display("FAIL route_ackerr got %b exp 1100",
                     {m1_ack, m1_err, m0_ack, m0_err});
        end
        step();
        s_ack = 1'b0; s_err = 1'b0;
        m1_we = 1'b1; m1_dat = 32'h1234_5678;
        #1;
        vectors++;
        if ({s_we, s_dat} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL route_wr got we=%b dat=%h exp 1 12345678", s_we, s_dat);
        end
        step();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        step();
        step();
    endtask

    task automatic test_watchdog();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            vectors++;
            if ({m0_err, tmo, m1_err} !== {(k == 5), (k == 5), 1'b0}) begin
                errors++;
                $display("FAIL wdt_cyc%0d got err/tmo/err1=%b exp %b%b0", k,
                         {m0_err, tmo, m1_err}, (k == 5), (k == 5));
            end
            vectors++;
            if ({z_m0_err, z_tmo} !== 2'b00) begin
                errors++;
                $display("FAIL nowdt_cyc%0d got %b exp 00", k, {z_m0_err, z_tmo});
            end
            step();
        end
        m0_cyc = 1'b0;
        #1;
        vectors++;
        if ({s_cyc, m0_err, m0_ack, tmo} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_resp got %b exp 0000", {s_cyc, m0_err, m0_ack, tmo});
        end
        step();
        vectors++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL abort_idle got %b exp 00", gnt);
        end
        m0_cyc = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) begin
            vectors++;
            if ({m0_err, tmo} !== {(k == 5), (k == 5)}) begin
                errors++;
                $display("FAIL wdt_rerun%0d got %b exp %b%b", k,
                         {m0_err, tmo}, (k == 5), (k == 5));
            end
            step();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_midop();
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        vectors++;
        if ({gnt, s_cyc} !== 3'b101) begin
            errors++; $display("FAIL midop_own got %b exp 101", {gnt, s_cyc});
        end
        rst = 1'b1;
        step();
        s_ack = 1'b1;
        #1;
        vectors++;
        if ({gnt, s_cyc, m1_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL midop_rst got %b exp 0000", {gnt, s_cyc, m1_ack});
        end
        s_ack = 1'b0;
        rst = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        m0_adr = '0; m0_dat = '0; m0_sel = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat_in = '0;
        test_reset();
        test_round_robin();
        test_hold();
        test_routing();
        test_watchdog();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
